rom_release_seq: RTL and testbench

Boot-release sequencer that produces the ROM-release request consumed by the card-ROM inhibit stage. It synchronizes a set of asynchronous subsystem-ready flags, requires all unmasked flags to be stably high for a programmable number of cycles, and then raises a level request. A watchdog timeout or a forced command can also raise the request. The block tracks the card-ROM enable returned by the consumer, so it knows when the handoff has completed.

---
 rtl/rom_release_seq.sv | 103 ++++++++++
 tb/tb_rom_release_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_release_seq.sv
// Boot-release sequencer: waits for synchronized, unmasked ready flags to hold for STABLE_CYCLES.
// It then raises a level ROM-release request; a timeout or a force command can raise it early.
module rom_release_seq #(
    parameter int unsigned NUM_READY      = 4,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
    input  logic                 clk_logic,
    input  logic                 system_reset_n,
    input  logic [NUM_READY-1:0] ready_i,
    input  logic [NUM_READY-1:0] ready_mask_i,
    input  logic                 force_release_i,
    input  logic                 rom_en_i,
    output logic                 req_rom_release_o,
    output logic                 fault_o,
    output logic [NUM_READY-1:0] ready_sync_o,
    output logic [1:0]           state_o
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_STABLE  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state;
    logic [SW-1:0]        stable_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic [NUM_READY-1:0] sync1;
    logic [NUM_READY-1:0] sync2;

    logic all_ok;
    logic armed;
    logic stable_done;
    logic tmo_hit;

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ready_i;
            sync2 <= sync1;
        end
    end

    assign all_ok      = &(sync2 | ~ready_mask_i);
    assign armed       = (state == ST_WAIT) || (state == ST_STABLE);
    assign stable_done = (state == ST_STABLE) && all_ok && (stable_cnt == STABLE_LAST);
    assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state      <= ST_WAIT;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
            fault_o    <= 1'b0;
        end else begin
            if (armed && (tmo_cnt != '1)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            case (state)
                ST_WAIT, ST_STABLE: begin
                    // Ordering encodes release priority; fault only when the timeout acts alone.
                    if (!rom_en_i) begin
                        state <= ST_DONE;
                    end else if (stable_done || force_release_i) begin
                        state <= ST_RELEASE;
                    end else if (tmo_hit) begin
                        state   <= ST_RELEASE;
                        fault_o <= 1'b1;
                    end else if (!all_ok) begin
                        state      <= ST_WAIT;
                        stable_cnt <= '0;
                    end else if (state == ST_WAIT) begin
                        state      <= ST_STABLE;
                        stable_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!rom_en_i) begin
                        state <= ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // RELEASE and DONE share bit 1, so the request is a bare flop output.
    assign req_rom_release_o = state[1];
    assign ready_sync_o      = sync2;
    assign state_o           = state;

endmodule

// File: tb/tb_rom_release_seq.sv
// Directed testbench for rom_release_seq: NUM_READY=2, STABLE_CYCLES=4, TIMEOUT_CYCLES=64.
// Edge n means the nth rising clk_logic edge after reset deassertion; checks land 1 ns after an edge.
module tb_rom_release_seq;

    logic       clk_logic;
    logic       system_reset_n;
    logic [1:0] ready_i;
    logic [1:0] ready_mask_i;
    logic       force_release_i;
    logic       rom_en_i;
    logic       req_rom_release_o;
    logic       fault_o;
    logic [1:0] ready_sync_o;
    logic [1:0] state_o;

    int vectors;
    int miscompares;

    rom_release_seq #(
        .NUM_READY      (2),
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_logic         (clk_logic),
        .system_reset_n    (system_reset_n),
        .ready_i           (ready_i),
        .ready_mask_i      (ready_mask_i),
        .force_release_i   (force_release_i),
        .rom_en_i          (rom_en_i),
        .req_rom_release_o (req_rom_release_o),
        .fault_o           (fault_o),
        .ready_sync_o      (ready_sync_o),
        .state_o           (state_o)
    );

    initial begin
        clk_logic = 1'b0;
        forever #5 clk_logic = ~clk_logic;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_logic);
        #1;
    endtask

    // Leaves the bench just after deassertion, before edge 1.
    task automatic do_reset(input logic [1:0] rdy, input logic [1:0] msk);
        system_reset_n  = 1'b0;
        ready_i         = rdy;
        ready_mask_i    = msk;
        force_release_i = 1'b0;
        rom_en_i        = 1'b1;
        repeat (3) @(posedge clk_logic);
        @(negedge clk_logic);
        system_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        system_reset_n = 1'b0;
        ready_i = 2'b11; ready_mask_i = 2'b11; force_release_i = 1'b1; rom_en_i = 1'b1;
        tick(3);
        vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state_o); end
        vectors++; if (req_rom_release_o !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", req_rom_release_o); end
        vectors++; if (fault_o !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", fault_o); end
        vectors++; if (ready_sync_o !== 2'b00) begin miscompares++; $display("FAIL reset_sync: got %b want 00", ready_sync_o); end
    endtask

    task automatic test_nominal();
        do_reset(2'b00, 2'b11);
        tick(9);
        ready_i = 2'b11;                      // first sampled at edge 10
        tick(1);
        vectors++; if (ready_sync_o !== 2'b00) begin miscompares++; $display("FAIL nom_sync_e10: got %b want 00", ready_sync_o); end
        tick(1);
        vectors++; if (ready_sync_o !== 2'b11) begin miscompares++; $display("FAIL nom_sync_e11: got %b want 11", ready_sync_o); end
        vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL nom_state_e11: got %0d want 0", state_o); end
        tick(1);
        vectors++; if (state_o !== 2'd1) begin miscompares++; $display("FAIL nom_state_e12: got %0d want 1", state_o); end
        tick(3);
        vectors++; if (req_rom_release_o !== 1'b0) begin miscompares++; $display("FAIL nom_req_e15: got %b want 0", req_rom_release_o); end
        tick(1);
        vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL nom_state_e16: got %0d want 2", state_o); end
        vectors++; if (req_rom_release_o !== 1'b1) begin miscompares++; $display("FAIL nom_req_e16: got %b want 1", req_rom_release_o); end
        tick(3);
        vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL nom_hold_e19: got %0d want 2", state_o); end
        rom_en_i = 1'b0;                      // sampled at edge 20
        tick(1);
        vectors++; if (state_o !== 2'd3) begin miscompares++; $display("FAIL nom_done_e20: got %0d want 3", state_o); end
        vectors++; if (req_rom_release_o !== 1'b1) begin miscompares++; $display("FAIL nom_done_req: got %b want 1", req_rom_release_o); end
        vectors++; if (fault_o !== 1'b0) begin miscompares++; $display("FAIL nom_done_fault: got %b want 0", fault_o); end
        ready_i = 2'b00; rom_en_i = 1'b1;
        tick(4);
        vectors++; if (state_o !== 2'd3) begin miscompares++; $display("FAIL nom_done_sticky: got %0d want 3", state_o); end
    endtask

    task automatic test_glitch();
        do_reset(2'b11, 2'b11);               // M = edge 1, STABLE at edge 3
        tick(4);
        ready_i = 2'b10;                      // bit0 low only at edge 5
        tick(1);
        ready_i = 2'b11;
        tick(1);
        vectors++; if (state_o !== 2'd1) begin miscompares++; $display("FAIL gl_state_e6: got %0d want 1", state_o); end
        tick(1);
        vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL gl_state_e7: got %0d want 0", state_o); end
        tick(1);
        vectors++; if (state_o !== 2'd1) begin miscompares++; $display("FAIL gl_state_e8: got %0d want 1", state_o); end
        tick(3);
        vectors++; if (req_rom_release_o !== 1'b0) begin miscompares++; $display("FAIL gl_req_e11: got %b want 0", req_rom_release_o); end
        tick(1);
        vectors++; if (req_rom_release_o !== 1'b1) begin miscompares++; $display("FAIL gl_req_e12: got %b want 1", req_rom_release_o); end

        // bit1 masked and toggling: the nominal release at edge 7 must be unaffected
        do_reset(2'b01, 2'b01);
        for (int i = 1; i <= 6; i++) begin
            ready_i[1] = ~ready_i[1];
            tick(1);
        end
        vectors++; if (state_o !== 2'd1) begin miscompares++; $display("FAIL mask_state_e6: got %0d want 1", state_o); end
        tick(1);
        vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL mask_state_e7: got %0d want 2", state_o); end

        // all bits masked: all_ok is constant, STABLE at edge 1, RELEASE at edge 5
        do_reset(2'b00, 2'b00);
        tick(1);
        vectors++; if (state_o !== 2'd1) begin miscompares++; $display("FAIL allmask_e1: got %0d want 1", state_o); end
        tick(3);
        vectors++; if (state_o !== 2'd1) begin miscompares++; $display("FAIL allmask_e4: got %0d want 1", state_o); end
        tick(1);
        vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL allmask_e5: got %0d want 2", state_o); end
    endtask

    task automatic test_timeout();
        do_reset(2'b00, 2'b11);
        tick(63);
        vectors++; if (req_rom_release_o !== 1'b0) begin miscompares++; $display("FAIL tmo_req_e63: got %b want 0", req_rom_release_o); end
        vectors++; if (fault_o !== 1'b0) begin miscompares++; $display("FAIL tmo_fault_e63: got %b want 0", fault_o); end
        tick(1);
        vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL tmo_state_e64: got %0d want 2", state_o); end
        vectors++; if (req_rom_release_o !== 1'b1) begin miscompares++; $display("FAIL tmo_req_e64: got %b want 1", req_rom_release_o); end
        vectors++; if (fault_o !== 1'b1) begin miscompares++; $display("FAIL tmo_fault_e64: got %b want 1", fault_o); end
        rom_en_i = 1'b0;
        tick(1);
        vectors++; if (state_o !== 2'd3) begin miscompares++; $display("FAIL tmo_done: got %0d want 3", state_o); end
        vectors++; if (fault_o !== 1'b1) begin miscompares++; $display("FAIL tmo_fault_sticky: got %b want 1", fault_o); end
    endtask

    task automatic test_force();
        do_reset(2'b00, 2'b11);
        tick(6);
        vectors++; if (req_rom_release_o !== 1'b0) begin miscompares++; $display("FAIL frc_req_e6: got %b want 0", req_rom_release_o); end
        force_release_i = 1'b1;               // sampled at edge 7
        tick(1);
        force_release_i = 1'b0;
        vectors++; if (req_rom_release_o !== 1'b1) begin miscompares++; $display("FAIL frc_req_e7: got %b want 1", req_rom_release_o); end
        vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL frc_state_e7: got %0d want 2", state_o); end
        vectors++; if (fault_o !== 1'b0) begin miscompares++; $display("FAIL frc_fault_e7: got %b want 0", fault_o); end

        do_reset(2'b00, 2'b11);
        tick(63);
        force_release_i = 1'b1;               // coincides with timeout edge 64
        tick(1);
        force_release_i = 1'b0;
        vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL frc_tmo_state: got %0d want 2", state_o); end
        vectors++; if (fault_o !== 1'b0) begin miscompares++; $display("FAIL frc_tmo_fault: got %b want 0", fault_o); end

        // rom_en_i low in WAIT outranks force and goes straight to DONE
        do_reset(2'b00, 2'b11);
        tick(2);
        rom_en_i = 1'b0; force_release_i = 1'b1;
        tick(1);
        force_release_i = 1'b0;
        vectors++; if (state_o !== 2'd3) begin miscompares++; $display("FAIL romen_wait_state: got %0d want 3", state_o); end
        vectors++; if (req_rom_release_o !== 1'b1) begin miscompares++; $display("FAIL romen_wait_req: got %b want 1", req_rom_release_o); end
    endtask

    task automatic test_reset_mid();
        do_reset(2'b11, 2'b11);
        tick(8);
        vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL mid_pre_state: got %0d want 2", state_o); end
        #2 system_reset_n = 1'b0;
        #1;
        vectors++; if (req_rom_release_o !== 1'b0) begin miscompares++; $display("FAIL mid_req: got %b want 0", req_rom_release_o); end
        vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL mid_state: got %0d want 0", state_o); end
        vectors++; if (ready_sync_o !== 2'b00) begin miscompares++; $display("FAIL mid_sync: got %b want 00", ready_sync_o); end
        @(negedge clk_logic);
        system_reset_n = 1'b1;                // ready still high: M = edge 1
        tick(2);
        vectors++; if (ready_sync_o !== 2'b11) begin miscompares++; $display("FAIL mid_rep_sync_e2: got %b want 11", ready_sync_o); end
        vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL mid_rep_state_e2: got %0d want 0", state_o); end
        tick(1);
        vectors++; if (state_o !== 2'd1) begin miscompares++; $display("FAIL mid_rep_state_e3: got %0d want 1", state_o); end
        tick(3);
        vectors++; if (req_rom_release_o !== 1'b0) begin miscompares++; $display("FAIL mid_rep_req_e6: got %b want 0", req_rom_release_o); end
        tick(1);
        vectors++; if (req_rom_release_o !== 1'b1) begin miscompares++; $display("FAIL mid_rep_req_e7: got %b want 1", req_rom_release_o); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_force();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
